// File: rtl/bcd_sum_requester.sv
// rtl/bcd_sum_requester.sv - APB master that runs one BCD summator add per command.
// Optional: BCD_REQ_OPERAND_CHECK_EN rejects non-BCD operands before any bus activity.
module bcd_sum_requester #(
  parameter int summatorBaseAddr = 0,
  parameter int addrWidth        = 10,
  parameter int dataWidth        = 16,
  parameter int accessTimeout    = 16,
  parameter int pollLimit        = 255,
  parameter int startWait        = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [dataWidth-1:0] cmd_arg1,
  input  logic [dataWidth-1:0] cmd_arg2,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [dataWidth-1:0] rsp_result,
  output logic                 rsp_overflow,
  output logic                 rsp_error,
  output logic                 aps_psel,
  output logic                 aps_penable,
  output logic                 aps_pwrite,
  output logic [addrWidth-1:0] aps_paddr,
  output logic [dataWidth-1:0] aps_pwdata,
  input  logic [dataWidth-1:0] aps_prdata,
  input  logic                 aps_pready,
  input  logic                 aps_pslverr
);

  localparam int L  = dataWidth / 8;
  localparam int RW = (pollLimit > 0) ? $clog2(pollLimit + 1) : 1;
  localparam int CW = $clog2(accessTimeout + startWait + 4);

  localparam logic [addrWidth-1:0] A_ARG1 = addrWidth'(summatorBaseAddr);
  localparam logic [addrWidth-1:0] A_ARG2 = addrWidth'(summatorBaseAddr + L);
  localparam logic [addrWidth-1:0] A_RES  = addrWidth'(summatorBaseAddr + 2 * L);
  localparam logic [addrWidth-1:0] A_STAT = addrWidth'(summatorBaseAddr + 3 * L);

  typedef enum logic [2:0] {IDLE, CHECK, XFER_SETUP, XFER_ACCESS, GAP, WAIT_START, RESP} state_t;
  typedef enum logic [2:0] {WR_ARG1, WR_ARG2, WR_START, WAIT_GO, RD_RES, RD_STAT, DONE} step_t;

  state_t               state_q, state_d;
  step_t                step_q, step_d;
  logic [dataWidth-1:0] arg1_q, arg1_d, arg2_q, arg2_d, res_q, res_d;
  logic                 ovf_q, ovf_d, err_q, err_d;
  logic [RW-1:0]        retry_q, retry_d;
  logic [CW-1:0]        cnt_q, cnt_d;

`ifdef BCD_REQ_OPERAND_CHECK_EN
  function automatic logic bcd_ok(input logic [dataWidth-1:0] v);
    for (int i = 0; i < dataWidth / 4; i++) begin
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      step_q  <= WR_ARG1;
      arg1_q  <= '0;
      arg2_q  <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      retry_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      arg1_q  <= arg1_d;
      arg2_q  <= arg2_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      retry_q <= retry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    arg1_d  = arg1_q;
    arg2_d  = arg2_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    retry_d = retry_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          arg1_d  = cmd_arg1;
          arg2_d  = cmd_arg2;
          res_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          retry_d = '0;
          step_d  = WR_ARG1;
          state_d = CHECK;
        end
      end
      CHECK: begin
`ifdef BCD_REQ_OPERAND_CHECK_EN
        if (!bcd_ok(arg1_q) || !bcd_ok(arg2_q)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          state_d = XFER_SETUP;
        end
`else
        state_d = XFER_SETUP;
`endif
      end
      XFER_SETUP: state_d = XFER_ACCESS;
      XFER_ACCESS: begin
        if (aps_pready) begin
          state_d = GAP;
          case (step_q)
            WR_ARG1:  step_d = WR_ARG2;
            WR_ARG2:  step_d = WR_START;
            WR_START: step_d = WAIT_GO;
            RD_RES: begin
              // slverr on a result read means the summator is still busy
              if (aps_pslverr) begin
                if (retry_q >= RW'(pollLimit)) state_d = RESP;
                else retry_d = retry_q + 1'b1;
              end else begin
                res_d  = aps_prdata;
                step_d = RD_STAT;
              end
            end
            RD_STAT: begin
              ovf_d  = aps_prdata[0];
              step_d = DONE;
            end
            default: state_d = RESP;
          endcase
          if (aps_pslverr && step_q != RD_RES) state_d = RESP;
        end else if (cnt_q >= CW'(accessTimeout - 1)) begin
          state_d = RESP;
        end
        if (state_d == RESP) begin
          err_d = 1'b1;
          res_d = '0;
          ovf_d = 1'b0;
        end
      end
      GAP: begin
        if (cnt_q == CW'(1)) begin
          case (step_q)
            WAIT_GO: begin
              if (startWait == 0) begin
                step_d  = RD_RES;
                state_d = XFER_SETUP;
              end else begin
                state_d = WAIT_START;
              end
            end
            DONE:    state_d = RESP;
            default: state_d = XFER_SETUP;
          endcase
        end
      end
      WAIT_START: begin
        if (cnt_q >= CW'(startWait - 1)) begin
          step_d  = RD_RES;
          state_d = XFER_SETUP;
        end
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cnt_q counts cycles spent in the current state and restarts on every transition
  assign cnt_d = (state_d != state_q) ? '0 : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);

  assign aps_psel    = (state_q == XFER_SETUP) || (state_q == XFER_ACCESS);
  assign aps_penable = (state_q == XFER_ACCESS);

  always_comb begin
    aps_paddr  = '0;
    aps_pwrite = 1'b0;
    aps_pwdata = '0;
    if (aps_psel) begin
      case (step_q)
        WR_ARG1:  begin aps_paddr = A_ARG1; aps_pwrite = 1'b1; aps_pwdata = arg1_q; end
        WR_ARG2:  begin aps_paddr = A_ARG2; aps_pwrite = 1'b1; aps_pwdata = arg2_q; end
        WR_START: begin aps_paddr = A_STAT; aps_pwrite = 1'b1; aps_pwdata = dataWidth'(1); end
        RD_RES:   aps_paddr = A_RES;
        RD_STAT:  aps_paddr = A_STAT;
        default:  aps_paddr = '0;
      endcase
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == RESP);
  assign rsp_result   = res_q;
  assign rsp_overflow = ovf_q;
  assign rsp_error    = err_q;

endmodule
